// File: rtl/encoder_8to3_scan.sv
// Registered 8-to-3 encoder: accepts a mask over valid/ready and emits one index
// per set bit in priority order, with last/zero/beat side-band flags.
module encoder_8to3_scan #(
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] eight_input,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [2:0] three_output,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       out_zero,
    output logic [2:0] out_beat
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    logic [0:0] state_q, state_d;
    logic [7:0] mask_q, mask_d;
    logic [2:0] idx_q, idx_d;
    logic       valid_q, valid_d;
    logic       last_q, last_d;
    logic       zero_q, zero_d;
    logic [2:0] beat_q, beat_d;

    logic [7:0] src;
    logic [7:0] src_clr;
    logic [2:0] pick;

    // The first beat encodes straight from the input; later beats from the residual mask.
    always_comb begin
        src  = (state_q == IDLE) ? eight_input : mask_q;
        pick = 3'd0;
        if (MSB_FIRST != 0) begin
            for (int i = 0; i < 8; i++) begin
                if (src[i]) pick = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (src[i]) pick = 3'(i);
            end
        end
        src_clr = src & ~(8'b1 << pick);
    end

    assign in_ready = (state_q == IDLE) && rst_n;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        last_d  = last_q;
        zero_d  = zero_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_d = EMIT;
                    idx_d   = pick;
                    mask_d  = src_clr;
                    last_d  = (src_clr == 8'd0);
                    zero_d  = (src == 8'd0);
                    beat_d  = 3'd0;
                    valid_d = 1'b1;
                end
            end
            EMIT: begin
                if (valid_q && out_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        zero_d  = 1'b0;
                    end else begin
                        idx_d  = pick;
                        mask_d = src_clr;
                        last_d = (src_clr == 8'd0);
                        beat_d = beat_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mask_q  <= 8'd0;
            idx_q   <= 3'd0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            zero_q  <= 1'b0;
            beat_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            zero_q  <= zero_d;
            beat_q  <= beat_d;
        end
    end

    assign three_output = idx_q;
    assign out_valid    = valid_q;
    assign out_last     = last_q;
    assign out_zero     = zero_q;
    assign out_beat     = beat_q;

endmodule

// File: tb/tb_encoder_8to3_scan.sv
// Bench for encoder_8to3_scan: MSB-first and LSB-first instances share stimulus;
// a scoreboard of expected beats is checked on every output handshake.
module tb_encoder_8to3_scan;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] eight_input = 8'd0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;

    logic       m_in_ready, m_valid, m_last, m_zero;
    logic [2:0] m_three, m_beat;
    logic       l_in_ready, l_valid, l_last, l_zero;
    logic [2:0] l_three, l_beat;

    int errors = 0;
    int checks = 0;

    // Expected beat packed as {idx[2:0], last, zero, beat[2:0]}.
    logic [7:0] q_m[$];
    logic [7:0] q_l[$];
    logic [7:0] exp_m, exp_l;

    always #5 clk = ~clk;

    encoder_8to3_scan #(.MSB_FIRST(1)) dut_m (
        .clk(clk), .rst_n(rst_n), .eight_input(eight_input), .in_valid(in_valid),
        .in_ready(m_in_ready), .three_output(m_three), .out_valid(m_valid),
        .out_ready(out_ready), .out_last(m_last), .out_zero(m_zero), .out_beat(m_beat)
    );

    encoder_8to3_scan #(.MSB_FIRST(0)) dut_l (
        .clk(clk), .rst_n(rst_n), .eight_input(eight_input), .in_valid(in_valid),
        .in_ready(l_in_ready), .three_output(l_three), .out_valid(l_valid),
        .out_ready(out_ready), .out_last(l_last), .out_zero(l_zero), .out_beat(l_beat)
    );

    // Scoreboard: compare each handshaken beat against the head of the queue.
    always @(negedge clk) begin
        if (rst_n && out_ready) begin
            if (m_valid) begin
                checks++;
                if (q_m.size() == 0) begin
                    errors++;
                    $display("FAIL beat_msb: unexpected beat idx=%0d, want no beat", m_three);
                end else begin
                    exp_m = q_m.pop_front();
                    if ({m_three, m_last, m_zero, m_beat} !== exp_m) begin
                        errors++;
                        $display("FAIL beat_msb: got idx=%0d last=%0b zero=%0b beat=%0d, want idx=%0d last=%0b zero=%0b beat=%0d",
                                 m_three, m_last, m_zero, m_beat,
                                 exp_m[7:5], exp_m[4], exp_m[3], exp_m[2:0]);
                    end
                end
            end
            if (l_valid) begin
                checks++;
                if (q_l.size() == 0) begin
                    errors++;
                    $display("FAIL beat_lsb: unexpected beat idx=%0d, want no beat", l_three);
                end else begin
                    exp_l = q_l.pop_front();
                    if ({l_three, l_last, l_zero, l_beat} !== exp_l) begin
                        errors++;
                        $display("FAIL beat_lsb: got idx=%0d last=%0b zero=%0b beat=%0d, want idx=%0d last=%0b zero=%0b beat=%0d",
                                 l_three, l_last, l_zero, l_beat,
                                 exp_l[7:5], exp_l[4], exp_l[3], exp_l[2:0]);
                    end
                end
            end
        end
    end

    task automatic push_expected(input logic [7:0] m);
        int p;
        int k;
        p = $countones(m);
        if (p == 0) begin
            q_m.push_back({3'd0, 1'b1, 1'b1, 3'd0});
            q_l.push_back({3'd0, 1'b1, 1'b1, 3'd0});
        end else begin
            k = 0;
            for (int i = 7; i >= 0; i--) begin
                if (m[i]) begin
                    q_m.push_back({3'(i), (k == p - 1), 1'b0, 3'(k)});
                    k++;
                end
            end
            k = 0;
            for (int i = 0; i < 8; i++) begin
                if (m[i]) begin
                    q_l.push_back({3'(i), (k == p - 1), 1'b0, 3'(k)});
                    k++;
                end
            end
        end
    endtask

    // Returns at accepting edge + #1 with in_valid dropped.
    task automatic send(input logic [7:0] m);
        bit ok;
        push_expected(m);
        @(posedge clk); #1;
        eight_input = m;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (m_in_ready && l_in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_accept: in_ready=%0b/%0b, want 1", m_in_ready, l_in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        eight_input = 8'($urandom);
    endtask

    task automatic drain(input string name);
        bit ok;
        @(posedge clk); #1;
        out_ready = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (q_m.size() == 0 && q_l.size() == 0 && m_in_ready && l_in_ready
                && !m_valid && !l_valid) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain_%s: pending=%0d/%0d in_ready=%0b/%0b, want 0/0 and 1/1",
                     name, q_m.size(), q_l.size(), m_in_ready, l_in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({m_valid, m_last, m_zero, m_three, m_beat} !== 9'd0) begin
            errors++;
            $display("FAIL reset_msb_outputs: got %b, want 0", {m_valid, m_last, m_zero, m_three, m_beat});
        end
        checks++;
        if ({l_valid, l_last, l_zero, l_three, l_beat} !== 9'd0) begin
            errors++;
            $display("FAIL reset_lsb_outputs: got %b, want 0", {l_valid, l_last, l_zero, l_three, l_beat});
        end
        checks++;
        if ({m_in_ready, l_in_ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_in_ready_low: got %b, want 00", {m_in_ready, l_in_ready});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({m_in_ready, l_in_ready} !== 2'b11) begin
            errors++;
            $display("FAIL reset_in_ready_idle: got %b, want 11", {m_in_ready, l_in_ready});
        end
    endtask

    task automatic test_onehot_walk();
        logic [7:0] m;
        for (int i = 0; i < 8; i++) begin
            m = 8'b1 << i;
            send(m);
            @(negedge clk);
            // Decoder loop-back: a one-hot of index i must re-encode to i.
            checks++;
            if (m_three !== 3'(i) || l_three !== 3'(i) || !m_valid || !m_last) begin
                errors++;
                $display("FAIL onehot_loopback: mask=%h got %0d/%0d valid=%0b last=%0b, want %0d",
                         m, m_three, l_three, m_valid, m_last, i);
            end
            drain("onehot");
        end
    endtask

    task automatic test_multihot();
        out_ready = 1'b1;
        send(8'hA5);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (!m_valid || !l_valid || m_in_ready || l_in_ready) begin
                errors++;
                $display("FAIL multihot_stream: cycle %0d valid=%0b/%0b in_ready=%0b/%0b, want 11/00",
                         k, m_valid, l_valid, m_in_ready, l_in_ready);
            end
        end
        @(negedge clk);
        checks++;
        if (!m_in_ready || !l_in_ready || m_valid || l_valid) begin
            errors++;
            $display("FAIL multihot_ready_return: in_ready=%0b/%0b valid=%0b/%0b, want 11/00",
                     m_in_ready, l_in_ready, m_valid, l_valid);
        end
        drain("multihot");
    endtask

    task automatic test_zero();
        send(8'h00);
        @(negedge clk);
        checks++;
        if (!m_zero || !l_zero || m_three !== 3'd0 || !m_last) begin
            errors++;
            $display("FAIL zero_flags: zero=%0b/%0b idx=%0d last=%0b, want 1/1 0 1",
                     m_zero, l_zero, m_three, m_last);
        end
        drain("zero");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(8'h81);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (!m_valid || m_three !== 3'd7 || m_beat !== 3'd0 || l_three !== 3'd0
                || l_beat !== 3'd0) begin
                errors++;
                $display("FAIL backpressure_hold: cycle %0d valid=%0b idx=%0d/%0d beat=%0d/%0d, want 1 7/0 0/0",
                         k, m_valid, m_three, l_three, m_beat, l_beat);
            end
            @(posedge clk); #1;
            in_valid = (k % 2 == 0);
            eight_input = 8'($urandom);
        end
        in_valid = 1'b0;
        drain("backpressure");
    endtask

    task automatic test_full();
        send(8'hFF);
        drain("full");
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        send(8'hFF);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (m_valid || l_valid || !m_in_ready || !l_in_ready) begin
            errors++;
            $display("FAIL reset_mid: valid=%0b/%0b in_ready=%0b/%0b, want 00/11",
                     m_valid, l_valid, m_in_ready, l_in_ready);
        end
        checks++;
        if (q_m.size() != 5) begin
            errors++;
            $display("FAIL reset_mid_beats: pending=%0d, want 5", q_m.size());
        end
        q_m.delete();
        q_l.delete();
        send(8'h10);
        drain("after_reset");
    endtask

    initial begin
        test_reset();
        test_onehot_walk();
        test_multihot();
        test_zero();
        test_backpressure();
        test_full();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
